deadlock_watchdog_ctrl: RTL
===========================

Name: deadlock_watchdog_ctrl

Overview:
Supervisory controller for the per-layer HLS deadlock monitors (one per MVAU/FIFO instance).
- Aggregates the monitors' raw `block` outputs and qualifies them against a forward-progress indication.
- Declares a deadlock only after a programmable number of consecutive stalled cycles.
- Reports the offending monitor to a host/status interface through a valid/ready handshake.
- Sits beside the dataflow pipeline; never touches the datapath itself.

Parameters:
- N_MON, 4: number of monitor inputs; 1..32.
- TIMEOUT, 1024: consecutive qualifying cycles before a report; must be ≥2.
- CNT_W, clog2(TIMEOUT+1): stall counter width; derived, not overridden.
- IDX_W, max(1,clog2(N_MON)): index width; derived.

Ports:
- ap_clk, input, 1: sole clock, rising edge.
- ap_rst_n, input, 1: synchronous, active-low reset.
- enable, input, 1: watchdog armed.
- mon_block, input, N_MON: block flags from the deadlock monitors, bit i = monitor i.
- progress, input, 1: high in any cycle in which a pipeline stream handshake fired.
- clear_sticky, input, 1: single-cycle pulse; clears deadlock.
- report_valid, output, 1: report available.
- report_ready, input, 1: consumer accepts report.
- report_idx, output, IDX_W: lowest-indexed monitor blocking at detection.
- report_mask, output, N_MON: full mon_block snapshot at detection.
- deadlock, output, 1: sticky detection flag.
- report_count, output, 8: reports issued; saturates at 255.
- stall_cnt, output, CNT_W: current stall counter, for debug.

Behaviour:
- All state is updated on the ap_clk rising edge. With ap_rst_n=0 sampled:
  - FSM goes to IDLE.
  - report_valid=0, report_idx=0, report_mask=0, deadlock=0, report_count=0, stall_cnt=0.
- Reset mid-operation, including during REPORT, aborts immediately; no partial report survives.
- A cycle is *qualifying* when (|mon_block)=1 and progress=0. If progress=1 in the same cycle as any block bit, the cycle is not qualifying.
- IDLE:
  - stall_cnt=0.
  - enable=1 → WATCH.
- WATCH:
  - enable=0 → IDLE.
  - Qualifying → SUSPECT, stall_cnt=1.
  - Otherwise stay.
- SUSPECT:
  - enable=0 → IDLE, stall_cnt=0.
  - Non-qualifying → WATCH, stall_cnt=0.
  - Qualifying with stall_cnt==TIMEOUT-1 → REPORT:
    - latch report_mask=mon_block and report_idx=lowest set bit of mon_block, both from that cycle;
    - deadlock←1;
    - report_count←report_count+1, saturating at 255.
  - Any other qualifying cycle → stall_cnt+1.
  - The set of asserted block bits may change between cycles; only the OR matters for counting.
- REPORT:
  - report_valid=1; report_idx and report_mask are held stable.
  - enable is ignored; valid never drops without a handshake.
  - report_ready=1 → HOLD next cycle, report_valid=0.
  - report_ready may be high before valid; it has no effect outside REPORT.
- HOLD (suppresses re-reporting the same stall):
  - stall_cnt=0.
  - (|mon_block)=0 or progress=1 → WATCH, or IDLE if enable=0.
  - Otherwise stay.
- Latency: report_valid rises in the cycle after the TIMEOUT-th consecutive qualifying sample. Example with TIMEOUT=8: qualifying at edges 0..7 gives report_valid=1 after edge 7.
- deadlock:
  - Set on REPORT entry; cleared only by clear_sticky or reset.
  - If clear_sticky coincides with REPORT entry, the set wins.
  - clear_sticky does not affect FSM state, report_valid or report_count.
- Priority encoder: all-zero input gives index 0. This cannot occur on REPORT entry.

Decomposition:
- Package deadlock_mon_pkg holds:
  - FSM state encoding (IDLE, WATCH, SUSPECT, REPORT, HOLD);
  - REPORT_CNT_W=8;
  - the TIMEOUT minimum constant (2), with an elaboration check.
- One sub-module, dl_prio_enc: parameterised N_MON-to-IDX_W lowest-set-bit encoder, purely combinational.
- Everything else lives in deadlock_watchdog_ctrl.

Test Plan (N_MON=4, TIMEOUT=8):
1. Reset/arm: ap_rst_n=0 for 2 cycles, then enable=1 with mon_block=0 → all outputs 0, FSM in WATCH, report_valid never asserts over 100 cycles.
2. Basic detect: mon_block=4'b0110, progress=0 held from edge 0 → report_valid=1 after edge 7, report_idx=1, report_mask=0110, deadlock=1, report_count=1.
3. Progress break: mon_block=4'b1000 for 5 cycles, progress=1 for 1 cycle, then 8 more qualifying cycles → no report until after the 8th post-break cycle; stall_cnt is 0 after the break.
4. Handshake/hold: report_ready=0 for 3 cycles in REPORT → valid, idx and mask stable; then report_ready=1 → HOLD. Keep mon_block≠0 for 20 cycles → no second report. Drop mon_block → WATCH.
5. Disable/clear: enable=0 at stall_cnt=5 → IDLE, stall_cnt=0. clear_sticky pulse on the same edge as REPORT entry → deadlock=1. Later lone pulse → deadlock=0, report_count unchanged.
6. Saturation/reset mid-report: force 256 report cycles → report_count=255. Assert ap_rst_n=0 while report_valid=1 → report_valid=0 and all outputs 0 next cycle.

Source files
------------

// File: rtl/deadlock_mon_pkg.sv
// deadlock_mon_pkg: shared FSM encoding and constants for the deadlock watchdog.
// Rev 1.0
`default_nettype none

package deadlock_mon_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WATCH   = 3'd1,
    ST_SUSPECT = 3'd2,
    ST_REPORT  = 3'd3,
    ST_HOLD    = 3'd4
  } state_t;

  localparam int REPORT_CNT_W = 8;
  localparam int TIMEOUT_MIN  = 2;

endpackage

`default_nettype wire

// File: rtl/dl_prio_enc.sv
// dl_prio_enc: combinational lowest-set-bit encoder; all-zero input yields 0.
// Rev 1.0
`default_nettype none

module dl_prio_enc
  import deadlock_mon_pkg::*;
#(
  parameter int N_MON = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_MON-1:0] req,
  output logic [IDX_W-1:0] idx
);

  // Scan downward so the lowest set bit is the last one written.
  always_comb begin
    idx = '0;
    for (int i = N_MON - 1; i >= 0; i--) begin
      if (req[i]) idx = IDX_W'(i);
    end
  end

endmodule

`default_nettype wire

// File: rtl/deadlock_watchdog_ctrl.sv
// deadlock_watchdog_ctrl: qualifies monitor block flags against progress and reports
// sustained stalls over a valid/ready status interface. Rev 1.0
`default_nettype none

module deadlock_watchdog_ctrl
  import deadlock_mon_pkg::*;
#(
  parameter  int N_MON   = 4,
  parameter  int TIMEOUT = 1024,
  localparam int CNT_W   = $clog2(TIMEOUT + 1),
  localparam int IDX_W   = (N_MON > 1) ? $clog2(N_MON) : 1
) (
  input  logic                    ap_clk,
  input  logic                    ap_rst_n,
  input  logic                    enable,
  input  logic [N_MON-1:0]        mon_block,
  input  logic                    progress,
  input  logic                    clear_sticky,
  output logic                    report_valid,
  input  logic                    report_ready,
  output logic [IDX_W-1:0]        report_idx,
  output logic [N_MON-1:0]        report_mask,
  output logic                    deadlock,
  output logic [REPORT_CNT_W-1:0] report_count,
  output logic [CNT_W-1:0]        stall_cnt
);

  generate
    if (TIMEOUT < TIMEOUT_MIN) begin : g_timeout_chk
      $error("deadlock_watchdog_ctrl: TIMEOUT must be at least 2");
    end
    if (N_MON < 1 || N_MON > 32) begin : g_nmon_chk
      $error("deadlock_watchdog_ctrl: N_MON must be in 1..32");
    end
  endgenerate

  localparam logic [CNT_W-1:0] STALL_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] stall_nxt;
  logic             capture;
  logic             qual;
  logic             any_block;
  logic [IDX_W-1:0] enc_idx;

  assign any_block    = |mon_block;
  assign qual         = any_block && !progress;
  assign report_valid = (state == ST_REPORT);

  dl_prio_enc #(
    .N_MON (N_MON),
    .IDX_W (IDX_W)
  ) u_prio_enc (
    .req (mon_block),
    .idx (enc_idx)
  );

  always_comb begin
    state_nxt = state;
    stall_nxt = stall_cnt;
    capture   = 1'b0;
    case (state)
      ST_IDLE: begin
        stall_nxt = '0;
        if (enable) state_nxt = ST_WATCH;
      end
      ST_WATCH: begin
        stall_nxt = '0;
        if (!enable) begin
          state_nxt = ST_IDLE;
        end else if (qual) begin
          state_nxt = ST_SUSPECT;
          stall_nxt = CNT_W'(1);
        end
      end
      ST_SUSPECT: begin
        if (!enable) begin
          state_nxt = ST_IDLE;
          stall_nxt = '0;
        end else if (!qual) begin
          state_nxt = ST_WATCH;
          stall_nxt = '0;
        end else if (stall_cnt == STALL_LAST) begin
          state_nxt = ST_REPORT;
          capture   = 1'b1;
        end else begin
          stall_nxt = stall_cnt + 1'b1;
        end
      end
      // enable is deliberately ignored: a presented report must be consumed.
      ST_REPORT: begin
        if (report_ready) begin
          state_nxt = ST_HOLD;
          stall_nxt = '0;
        end
      end
      ST_HOLD: begin
        stall_nxt = '0;
        if (!any_block || progress) state_nxt = enable ? ST_WATCH : ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
        stall_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state        <= ST_IDLE;
      stall_cnt    <= '0;
      report_idx   <= '0;
      report_mask  <= '0;
      deadlock     <= 1'b0;
      report_count <= '0;
    end else begin
      state     <= state_nxt;
      stall_cnt <= stall_nxt;
      if (capture) begin
        report_idx  <= enc_idx;
        report_mask <= mon_block;
        if (report_count != '1) report_count <= report_count + 1'b1;
      end
      // Detection outranks a coincident clear.
      if (capture) deadlock <= 1'b1;
      else if (clear_sticky) deadlock <= 1'b0;
    end
  end

endmodule

`default_nettype wire
